// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and width helpers for the iterative divider
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
    function automatic logic [63:0] min_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration on a WIDTH+1 bit shifted partial remainder
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pr,
    input  logic [WIDTH-1:0] dvs,
    input  logic             din,
    output logic [WIDTH-1:0] pr_next,
    output logic             q
);
    logic [WIDTH:0] sh, diff;
    assign sh      = {pr, din};
    assign diff    = sh - {1'b0, dvs};
    assign q       = ~diff[WIDTH];
    assign pr_next = q ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
endmodule

// File: rtl/divide_seq.sv
// divide_seq: iterative signed/unsigned divider with start/ok handshake and defined divide-by-zero result
module divide_seq
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, rem_n, mag_a, mag_b;
    logic q_bit, neg_q, neg_r, sgn, neg_a, neg_b, go, bz;
    assign go    = start && (state == IDLE || state == DONE);
    assign bz    = B == '0;
    assign sgn   = SIGNED_EN && is_signed;
    assign neg_a = sgn && A[WIDTH-1];
    assign neg_b = sgn && B[WIDTH-1];
    assign mag_a = neg_a ? -A : A;
    assign mag_b = neg_b ? -B : B;
    assign ok    = state == DONE;
    assign busy  = state == CALC || state == FIX;
    div_step #(.WIDTH(WIDTH)) u_step (
        .pr     (rem),
        .dvs    (dvs),
        .din    (quo[WIDTH-1]),
        .pr_next(rem_n),
        .q      (q_bit)
    );
    always_comb begin
        state_n = state;
        if (go) state_n = bz ? DONE : CALC;
        else if (state == CALC && cnt == CW'(1)) state_n = FIX;
        else if (state == FIX) state_n = DONE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            D     <= '0;
            R     <= '0;
            err   <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_n;
            if (go) begin
                err   <= bz;
                dvs   <= mag_b;
                quo   <= mag_a;
                rem   <= '0;
                cnt   <= CW'(WIDTH);
                neg_q <= neg_a ^ neg_b;
                neg_r <= neg_a;
                if (bz) begin
                    D <= '1;
                    R <= A;
                end
            end else if (state == CALC) begin
                rem <= rem_n;
                quo <= {quo[WIDTH-2:0], q_bit};
                cnt <= cnt - 1'b1;
            end else if (state == FIX) begin
                D <= neg_q ? -quo : quo;
                R <= neg_r ? -rem : rem;
            end
        end
    end
endmodule

// File: tb/tb_divide_seq.sv
// tb_divide_seq: scoreboard bench for 32-bit and 8-bit divide_seq instances
module tb_divide_seq;
    import div_pkg::*;
    typedef struct packed {
        logic [31:0] d;
        logic [31:0] r;
        logic        e;
    } res_t;
    logic clk = 0, reset = 0, start = 0, is_signed = 0;
    logic [31:0] a = 0, b = 0, d, r;
    logic ok, err, busy;
    logic start8 = 0, s8 = 0;
    logic [7:0] a8 = 0, b8 = 0, d8, r8;
    logic ok8, err8, busy8;
    res_t sb[$];
    int tests = 0, fails = 0;
    divide_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .A(a), .B(b), .D(d), .R(r), .ok(ok), .err(err), .busy(busy)
    );
    divide_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(s8),
        .A(a8), .B(b8), .D(d8), .R(r8), .ok(ok8), .err(err8), .busy(busy8)
    );
    always #5 clk = ~clk;
    function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv, input bit s);
        longint m, sa, sbv, q, rm;
        res_t x;
        m = (longint'(1) << w) - 1;
        if (bv == 0) begin
            x.d = 32'(m);
            x.r = av;
            x.e = 1'b1;
            return x;
        end
        sa  = longint'(av);
        sbv = longint'(bv);
        if (s && av[w-1]) sa = sa - (longint'(1) << w);
        if (s && bv[w-1]) sbv = sbv - (longint'(1) << w);
        q   = sa / sbv;
        rm  = sa % sbv;
        x.d = 32'(q & m);
        x.r = 32'(rm & m);
        x.e = 1'b0;
        return x;
    endfunction
    task automatic go32(input logic [31:0] av, input logic [31:0] bv, input bit s);
        a = av; b = bv; is_signed = s; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask
    task automatic go8(input logic [7:0] av, input logic [7:0] bv, input bit s);
        a8 = av; b8 = bv; s8 = s; start8 = 1;
        @(posedge clk); #1;
        start8 = 0;
    endtask
    task automatic wait_ok32(output int cyc, output int bc);
        cyc = 1;
        bc  = int'(busy);
        while (!ok && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) bc++;
        end
    endtask
    task automatic wait_ok8(output int cyc);
        cyc = 1;
        while (!ok8 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask
    task automatic test_reset;
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({d, r, ok, err, busy} !== '0) begin
            fails++;
            $display("FAIL reset32: D=%h R=%h ok=%b err=%b busy=%b, want all 0", d, r, ok, err, busy);
        end
        tests++;
        if ({d8, r8, ok8, err8, busy8} !== '0) begin
            fails++;
            $display("FAIL reset8: D=%h R=%h ok=%b err=%b busy=%b, want all 0", d8, r8, ok8, err8, busy8);
        end
        reset = 1;
        @(posedge clk); #1;
    endtask
    task automatic test_unsigned;
        int cyc, bc;
        res_t e;
        sb.push_back('{32'd2, 32'd1, 1'b0});
        go32(32'd7, 32'd3, 0);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if (cyc !== 34 || bc !== 33) begin
            fails++;
            $display("FAIL unsigned_lat: ok at cycle %0d busy %0d cycles, want 34 and 33", cyc, bc);
        end
        tests++;
        if ({d, r, err} !== {e.d, e.r, e.e}) begin
            fails++;
            $display("FAIL unsigned_res: D=%h R=%h err=%b, want D=%h R=%h err=%b", d, r, err, e.d, e.r, e.e);
        end
    endtask
    task automatic test_signed;
        int cyc, bc;
        res_t e;
        sb.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0});
        sb.push_back('{32'hFFFF_FFF8, 32'd4, 1'b0});
        go32(32'hFFFF_FFF9, 32'd3, 1);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if ({d, r, err} !== {e.d, e.r, e.e} || cyc !== 34) begin
            fails++;
            $display("FAIL signed_neg_a: D=%h R=%h err=%b cyc=%0d, want D=%h R=%h err=%b cyc=34", d, r, err, cyc, e.d, e.r, e.e);
        end
        go32(32'h3C, 32'hFFFF_FFF9, 1);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if ({d, r, err} !== {e.d, e.r, e.e}) begin
            fails++;
            $display("FAIL signed_neg_b: D=%h R=%h err=%b, want D=%h R=%h err=%b", d, r, err, e.d, e.r, e.e);
        end
    endtask
    task automatic test_div_zero;
        int cyc, bc;
        res_t e;
        sb.push_back('{32'hFFFF_FFFF, 32'h0D, 1'b1});
        sb.push_back('{32'h0D, 32'd4, 1'b0});
        go32(32'h0D, 32'd0, 0);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if (cyc !== 1) begin
            fails++;
            $display("FAIL dz_lat: ok at cycle %0d, want 1", cyc);
        end
        tests++;
        if ({d, r, err} !== {e.d, e.r, e.e}) begin
            fails++;
            $display("FAIL dz_res: D=%h R=%h err=%b, want D=%h R=%h err=%b", d, r, err, e.d, e.r, e.e);
        end
        go32(32'h52, 32'd6, 0);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if ({d, r, err} !== {e.d, e.r, e.e}) begin
            fails++;
            $display("FAIL dz_after: D=%h R=%h err=%b, want D=%h R=%h err=%b", d, r, err, e.d, e.r, e.e);
        end
    endtask
    task automatic test_overflow;
        int cyc, bc;
        res_t e;
        logic [31:0] mn;
        mn = 32'(min_neg(32));
        sb.push_back('{mn, 32'd0, 1'b0});
        go32(mn, 32'hFFFF_FFFF, 1);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if ({d, r, err} !== {e.d, e.r, e.e} || cyc !== 34) begin
            fails++;
            $display("FAIL overflow: D=%h R=%h err=%b cyc=%0d, want D=%h R=%h err=%b cyc=34", d, r, err, cyc, e.d, e.r, e.e);
        end
    endtask
    task automatic test_busy_ignore;
        int cyc, bc;
        res_t e;
        sb.push_back('{32'h0E, 32'd2, 1'b0});
        go32(32'h64, 32'd7, 0);
        repeat (8) @(posedge clk);
        #1;
        go32(32'd1, 32'd1, 0);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if ({ok, d, r, err} !== {1'b1, e.d, e.r, e.e}) begin
            fails++;
            $display("FAIL busy_ignore: ok=%b D=%h R=%h err=%b, want ok=1 D=%h R=%h err=%b", ok, d, r, err, e.d, e.r, e.e);
        end
    endtask
    task automatic test_abort;
        bit seen;
        seen = 0;
        go32(32'h38, 32'd7, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk); #1;
        tests++;
        if ({d, r, ok, err, busy} !== '0) begin
            fails++;
            $display("FAIL abort: D=%h R=%h ok=%b err=%b busy=%b, want all 0", d, r, ok, err, busy);
        end
        reset = 1;
        repeat (40) begin
            @(posedge clk); #1;
            if (ok) seen = 1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL abort_no_ok: ok seen=%b, want 0", seen);
        end
    endtask
    task automatic test_back_to_back;
        int cyc, bc;
        res_t e;
        logic [31:0] av, bv;
        bit s;
        sb.push_back('{32'd5, 32'd0, 1'b0});
        go32(32'd25, 32'd5, 0);
        wait_ok32(cyc, bc);
        e = sb.pop_front();
        tests++;
        if ({d, r, err} !== {e.d, e.r, e.e}) begin
            fails++;
            $display("FAIL b2b_first: D=%h R=%h err=%b, want D=%h R=%h err=%b", d, r, err, e.d, e.r, e.e);
        end
        for (int i = 0; i < 8; i++) begin
            av = $urandom;
            bv = (i == 3) ? 32'd0 : (i[0] ? 32'($urandom_range(1, 60)) : $urandom);
            if (i == 5) bv = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (bv == 0 && i != 3) bv = 32'd1;
            s = i[1];
            sb.push_back(model(32, av, bv, s));
            go32(av, bv, s);
            tests++;
            if (ok !== (bv == 0)) begin
                fails++;
                $display("FAIL b2b_ok_drop%0d: ok=%b, want %b", i, ok, bv == 0);
            end
            wait_ok32(cyc, bc);
            e = sb.pop_front();
            tests++;
            if ({d, r, err} !== {e.d, e.r, e.e} || cyc !== ((bv == 0) ? 1 : 34)) begin
                fails++;
                $display("FAIL b2b_res%0d: A=%h B=%h s=%b D=%h R=%h err=%b cyc=%0d, want D=%h R=%h err=%b", i, av, bv, s, d, r, err, cyc, e.d, e.r, e.e);
            end
        end
    endtask
    task automatic test_width8;
        int cyc;
        res_t e;
        sb.push_back('{32'h0F, 32'h05, 1'b0});
        sb.push_back('{32'h80, 32'h00, 1'b0});
        go8(8'h6E, 8'h07, 0);
        wait_ok8(cyc);
        e = sb.pop_front();
        tests++;
        if ({d8, r8, err8} !== {e.d[7:0], e.r[7:0], e.e} || cyc !== 10) begin
            fails++;
            $display("FAIL w8_unsigned: D=%h R=%h err=%b cyc=%0d, want D=%h R=%h err=%b cyc=10", d8, r8, err8, cyc, e.d[7:0], e.r[7:0], e.e);
        end
        go8(8'h80, 8'hFF, 1);
        wait_ok8(cyc);
        e = sb.pop_front();
        tests++;
        if ({d8, r8, err8} !== {e.d[7:0], e.r[7:0], e.e}) begin
            fails++;
            $display("FAIL w8_overflow: D=%h R=%h err=%b, want D=%h R=%h err=%b", d8, r8, err8, e.d[7:0], e.r[7:0], e.e);
        end
    endtask
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
